uart_tx_arbiter: RTL and testbench

//  Shares one UART_TX serializer (25 MHz, 115200 baud, CLKS_PER_BIT=217) among NUM_REQ byte producers.

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/uart_rr_picker.sv | 54 +++++
 rtl/uart_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types and constants for the UART TX arbiter slice:
//                FSM state encoding and the byte width.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

   localparam int BYTE_W = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_BUSY   = 2'd2;
   localparam logic [1:0] ST_GAP    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_LAUNCH = ST_LAUNCH,
      S_BUSY   = ST_BUSY,
      S_GAP    = ST_GAP
   } arb_state_t;

endpackage : uart_arb_pkg

`default_nettype wire

// File: rtl/uart_rr_picker.sv
// ============================================================================
//  Module      : uart_rr_picker
//  Description : Combinational round-robin picker. Scans the request vector
//                starting one position after the pointer (wrapping modulo
//                NUM_REQ) and returns the first set request as a one-hot
//                grant and as a binary index.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   // One extra bit so ptr+offset can exceed NUM_REQ before wrapping
   localparam int SUM_W = IDX_W + 1;

   logic [SUM_W-1:0] w_sum;
   logic [IDX_W-1:0] w_cand;
   logic             w_found;

   assign o_any = |i_req;

   // Rotating priority scan: offset 1 first, offset NUM_REQ (the pointer itself) last
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_sum = {1'b0, i_ptr} + SUM_W'(i);
         if (w_sum >= SUM_W'(NUM_REQ)) begin
            w_sum = w_sum - SUM_W'(NUM_REQ);
         end
         w_cand = w_sum[IDX_W-1:0];
         if (!w_found && i_req[w_cand]) begin
            w_found         = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

endmodule : uart_rr_picker

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART_TX serializer among NUM_REQ byte producers.
//                Round-robin, one byte per grant; launches the TX with a
//                one-cycle DV pulse and waits for TX done before re-granting.
//                FSM: IDLE -> LAUNCH -> BUSY -> GAP -> IDLE.
//                Optional macro UART_ARB_TIMEOUT_EN adds a BUSY watchdog that
//                pulses o_Timeout and abandons the frame after TIMEOUT_CLKS.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 217,
   parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic [NUM_REQ-1:0]        i_Req_DV,
   input  logic [BYTE_W*NUM_REQ-1:0] i_Req_Byte,
   output logic [NUM_REQ-1:0]        o_Req_Ack,
   output logic                      o_TX_DV,
   output logic [BYTE_W-1:0]         o_TX_Byte,
   input  logic                      i_TX_Active,
   input  logic                      i_TX_Done,
   output logic                      o_Busy,
   output logic                      o_Timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || CLKS_PER_BIT < 1 || TIMEOUT_CLKS < 2) begin : g_param_check
      $error("uart_tx_arbiter: parameter out of range");
   end

   arb_state_t          r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
   logic [BYTE_W-1:0]   r_tx_byte, w_tx_byte_nxt;
   logic                r_tx_dv, w_tx_dv_nxt;
   logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
   logic                r_busy;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]    w_idx;
   logic                w_any;
   logic [BYTE_W-1:0]   w_sel_byte;

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .i_req   (i_Req_DV),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // AND-OR byte mux driven by the one-hot grant
   always_comb begin
      w_sel_byte = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_grant[k]) begin
            w_sel_byte = w_sel_byte | i_Req_Byte[k*BYTE_W +: BYTE_W];
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout, w_timeout_nxt;

   // Clocks since launch: the launch cycle itself counts as one, so BUSY's
   // first cycle reads 1; saturates so it cannot wrap while o_Timeout is high.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_cnt <= '0;
      end else if (r_state == S_LAUNCH) begin
         r_cnt <= CNT_W'(1);
      end else if (r_state == S_BUSY && r_cnt != CNT_W'(TIMEOUT_CLKS)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Timeout pulse register
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout_nxt;
      end
   end

   assign o_Timeout = r_timeout;
`else
   assign o_Timeout = 1'b0;
`endif

   // Next-state and next-output logic; request inputs only matter in IDLE
   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_tx_byte_nxt = r_tx_byte;
      w_tx_dv_nxt   = 1'b0;
      w_ack_nxt     = '0;
`ifdef UART_ARB_TIMEOUT_EN
      w_timeout_nxt = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            // UART_TX has no reset and may still be finishing a byte
            if (w_any && !i_TX_Active) begin
               w_state_nxt   = S_LAUNCH;
               w_ptr_nxt     = w_idx;
               w_tx_byte_nxt = w_sel_byte;
               w_tx_dv_nxt   = 1'b1;
               w_ack_nxt     = w_grant;
            end
         end
         S_LAUNCH: begin
            w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
            // Done wins over a timeout decided in the same cycle; after the
            // pulse the byte is treated as consumed.
            if (i_TX_Done || r_timeout) begin
               w_state_nxt = S_GAP;
            end else if (r_cnt == CNT_W'(TIMEOUT_CLKS - 1)) begin
               w_timeout_nxt = 1'b1;
            end
`else
            if (i_TX_Done) begin
               w_state_nxt = S_GAP;
            end
`endif
         end
         S_GAP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; pointer starts at NUM_REQ-1 so requester 0 wins first
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= IDX_W'(NUM_REQ - 1);
         r_tx_byte <= '0;
         r_tx_dv   <= 1'b0;
         r_ack     <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_tx_byte <= w_tx_byte_nxt;
         r_tx_dv   <= w_tx_dv_nxt;
         r_ack     <= w_ack_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign o_Req_Ack = r_ack;
   assign o_TX_DV   = r_tx_dv;
   assign o_TX_Byte = r_tx_byte;
   assign o_Busy    = r_busy;

endmodule : uart_tx_arbiter

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Scoreboard bench for uart_tx_arbiter with a behavioural
//                UART_TX (serial line, active, done) and a serial receiver.
//                Timeout scenario is built when UART_ARB_TIMEOUT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int NR  = 4;
   localparam int CPB = 217;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_dv = '0;
   logic [8*NR-1:0] req_byte = '0;
   logic [NR-1:0]   ack;
   logic            tx_dv;
   logic [7:0]      tx_byte;
   logic            tx_active = 1'b0;
   logic            tx_done = 1'b0;
   logic            busy;
   logic            tmo;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct packed {
      logic [7:0] idx;
      logic [7:0] byt;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] rx_exp[$];

   logic [7:0] rq_b[NR][4];
   int         rq_n[NR];
   int         rq_h[NR];

   int  last_done = -1;
   bit  gap_chk = 1'b0;
   bit  tmo_expected = 1'b0;
   int  unexp_tmo = 0;

   bit         tx_stub = 1'b0;
   bit         tx_kill = 1'b0;
   bit         tx_pend = 1'b0;
   logic [9:0] tx_sh = '1;
   int         tx_cnt = 0;
   int         tx_bit = 0;
   logic       tx_serial = 1'b1;

   bit         rx_busy = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh = '0;

   uart_tx_arbiter #(
      .NUM_REQ      (NR),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Req_DV    (req_dv),
      .i_Req_Byte  (req_byte),
      .o_Req_Ack   (ack),
      .o_TX_DV     (tx_dv),
      .o_TX_Byte   (tx_byte),
      .i_TX_Active (tx_active),
      .i_TX_Done   (tx_done),
      .o_Busy      (busy),
      .o_Timeout   (tmo)
   );

   always #20 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog: simulation exceeded cycle limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural UART_TX: registers DV, then start bit, 8 data LSB first, stop bit, done pulse
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         if (tx_kill) begin
            tx_active = 1'b0;
            tx_pend   = 1'b0;
            tx_serial = 1'b1;
         end else if (tx_pend) begin
            tx_pend   = 1'b0;
            tx_active = 1'b1;
            tx_cnt    = 0;
            tx_bit    = 0;
            tx_serial = tx_stub ? 1'b1 : 1'b0;
         end else if (tx_active && !tx_stub) begin
            if (tx_cnt == CPB - 1) begin
               tx_cnt = 0;
               if (tx_bit == 9) begin
                  tx_active = 1'b0;
                  tx_done   = 1'b1;
                  tx_serial = 1'b1;
               end else begin
                  tx_bit++;
                  tx_serial = tx_sh[tx_bit];
               end
            end else begin
               tx_cnt++;
            end
         end
         if (tx_dv && !tx_active && !tx_kill) begin
            tx_pend = 1'b1;
            tx_sh   = {1'b1, tx_byte, 1'b0};
         end
      end
   end

   // Serial receiver: samples mid-bit, checks stop bit and byte against the scoreboard
   initial begin
      int j;
      forever begin
         @(negedge clk);
         if (!rx_busy) begin
            if (tx_serial === 1'b0) begin
               rx_busy = 1'b1;
               rx_cnt  = 0;
            end
         end else begin
            rx_cnt++;
            if (rx_cnt >= CPB + CPB / 2 && (rx_cnt - CPB / 2) % CPB == 0) begin
               j = (rx_cnt - CPB / 2) / CPB;
               if (j <= 8) begin
                  rx_sh[j-1] = tx_serial;
               end else begin
                  rx_busy = 1'b0;
                  chk("rx_stop_bit", 32'(tx_serial), 32'd1);
                  if (rx_exp.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL rx_unexpected: received %0h with nothing expected", rx_sh);
                  end else begin
                     chk("rx_byte", 32'(rx_sh), 32'(rx_exp.pop_front()));
                  end
               end
            end
         end
      end
   end

   // Grant monitor: pops the expected grant at every launch pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (tx_dv) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL dv_unexpected: launch of %0h with no grant expected", tx_byte);
            end else begin
               e = sb.pop_front();
               chk("grant_ack", 32'(ack), 32'(1) << e.idx);
               chk("grant_byte", 32'(tx_byte), 32'(e.byt));
               chk("dv_while_active", 32'(tx_active), 32'd0);
               if (!tx_stub) rx_exp.push_back(e.byt);
               if (gap_chk && last_done >= 0) chk("frame_gap", 32'(cyc - last_done), 32'd3);
            end
         end
         if (ack != '0) chk("ack_onehot_with_dv", 32'({$onehot(ack), tx_dv}), 32'd3);
         if (tx_done) last_done = cyc;
         if (tmo && !tmo_expected) unexp_tmo++;
      end
   end

   task automatic drive_reqs();
      for (int k = 0; k < NR; k++) begin
         if (rq_h[k] < rq_n[k]) begin
            req_dv[k]           = 1'b1;
            req_byte[8*k +: 8]  = rq_b[k][rq_h[k]];
         end else begin
            req_dv[k]           = 1'b0;
            req_byte[8*k +: 8]  = 8'h00;
         end
      end
   endtask

   // One clock: retire acknowledged bytes, present the next ones
   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) begin
         if (ack[k] && rq_h[k] < rq_n[k]) rq_h[k]++;
      end
      drive_reqs();
   endtask

   task automatic add_req(input int k, input logic [7:0] b, input bit exp_grant);
      rq_b[k][rq_n[k]] = b;
      rq_n[k]++;
      if (exp_grant) sb.push_back('{idx: 8'(k), byt: b});
   endtask

   task automatic expect_grant(input int k, input logic [7:0] b);
      sb.push_back('{idx: 8'(k), byt: b});
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_ack"},  32'(ack),     32'd0);
      chk({pfx, "_dv"},   32'(tx_dv),   32'd0);
      chk({pfx, "_byte"}, 32'(tx_byte), 32'd0);
      chk({pfx, "_busy"}, 32'(busy),    32'd0);
      chk({pfx, "_tmo"},  32'(tmo),     32'd0);
   endtask

   task automatic do_reset(input string pfx);
      rst = 1'b1;
      for (int k = 0; k < NR; k++) begin
         rq_n[k] = 0;
         rq_h[k] = 0;
      end
      drive_reqs();
      step();
      step();
      chk_reset_outputs(pfx);
      rst = 1'b0;
   endtask

   function automatic bit all_done();
      bit d = 1'b1;
      for (int k = 0; k < NR; k++) begin
         if (rq_h[k] != rq_n[k]) d = 1'b0;
      end
      return d && !busy && !tx_active && !tx_pend && sb.size() == 0 &&
             rx_exp.size() == 0 && !rx_busy;
   endfunction

   task automatic run_until_idle(input string name, input int budget);
      bit ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         step();
         if (all_done()) ok = 1'b1;
      end
      chk({name, "_complete"}, 32'(ok), 32'd1);
   endtask

   initial begin
      int launch_cyc;
      int tmo_cyc;

      // Test 1: single byte, one-cycle latency
      do_reset("t1_reset");
      add_req(0, 8'h37, 1'b1);
      drive_reqs();
      step();
      chk("t1_dv_latency", 32'(tx_dv), 32'd1);
      chk("t1_ack_latency", 32'(ack), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      run_until_idle("t1", 4000);

      // Test 2: all four requesting -> rotation A0,A1,A2,A3,A0
      do_reset("t2_reset");
      add_req(0, 8'hA0, 1'b0);
      add_req(0, 8'hA0, 1'b0);
      add_req(1, 8'hA1, 1'b0);
      add_req(2, 8'hA2, 1'b0);
      add_req(3, 8'hA3, 1'b0);
      expect_grant(0, 8'hA0);
      expect_grant(1, 8'hA1);
      expect_grant(2, 8'hA2);
      expect_grant(3, 8'hA3);
      expect_grant(0, 8'hA0);
      drive_reqs();
      run_until_idle("t2", 15000);

      // Test 3: lone requester streams back to back, 3 clocks from done to launch
      do_reset("t3_reset");
      last_done = -1;
      gap_chk   = 1'b1;
      add_req(2, 8'h11, 1'b1);
      add_req(2, 8'h22, 1'b1);
      add_req(2, 8'h33, 1'b1);
      drive_reqs();
      run_until_idle("t3", 9000);
      gap_chk = 1'b0;

      // Test 4: reset in BUSY while the TX keeps running; no grant until it goes idle
      do_reset("t4_reset");
      add_req(0, 8'h44, 1'b1);
      drive_reqs();
      for (int c = 0; c < 300; c++) step();
      chk("t4_tx_active_before_reset", 32'(tx_active), 32'd1);
      rst = 1'b1;
      #1;
      chk_reset_outputs("t4_async_reset");
      add_req(1, 8'h5A, 1'b1);
      drive_reqs();
      step();
      step();
      step();
      chk_reset_outputs("t4_held_reset");
      rst = 1'b0;
      step();
      chk("t4_no_grant_while_active", 32'(tx_dv), 32'd0);
      run_until_idle("t4", 6000);

      // Test 6: req1 and req3 rise together after a grant to req1 -> req3 first
      do_reset("t6_reset");
      add_req(1, 8'h61, 1'b1);
      drive_reqs();
      run_until_idle("t6a", 4000);
      add_req(3, 8'h63, 1'b1);
      add_req(1, 8'h62, 1'b1);
      drive_reqs();
      run_until_idle("t6b", 8000);

      // Test 5: TX that never completes
      do_reset("t5_reset");
      tx_stub = 1'b1;
      add_req(3, 8'hFF, 1'b1);
      drive_reqs();
      step();
      chk("t5_launch", 32'(tx_dv), 32'd1);
      launch_cyc = cyc;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_expected = 1'b1;
      tmo_cyc = -1;
      for (int c = 0; c < 3000 && tmo_cyc < 0; c++) begin
         step();
         if (tmo) tmo_cyc = cyc;
      end
      chk("t5_timeout_delay", 32'(tmo_cyc - launch_cyc), 32'd2604);
      step();
      chk("t5_timeout_one_cycle", 32'(tmo), 32'd0);
      chk("t5_busy_after_1", 32'(busy), 32'd1);
      step();
      chk("t5_busy_after_2", 32'(busy), 32'd0);
      tmo_expected = 1'b0;
`else
      for (int c = 0; c < 2700; c++) step();
      chk("t5_still_busy", 32'(busy), 32'd1);
      chk("t5_no_timeout", 32'(tmo), 32'd0);
`endif
      chk("t5_scoreboard_empty", 32'(sb.size()), 32'd0);
      tx_kill = 1'b1;
      step();
      step();
      tx_kill = 1'b0;
      tx_stub = 1'b0;

      chk("no_stray_timeout", 32'(unexp_tmo), 32'd0);
      chk("rx_queue_drained", 32'(rx_exp.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_tx_arbiter

`default_nettype wire
